// File: rtl/loop_stack_ctrl.sv
// Nested hardware-loop controller for decode: a register stack of loop frames driving a branch-back redirect to fetch.
// Optional per-frame iteration index (ITER output) is built when LOOP_STACK_ITER_EN is defined.
module loop_stack_ctrl #(
    parameter int PC_WIDTH      = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int DEPTH         = 4,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [PC_WIDTH-1:0]        PC,
    input  logic                       STALL,
    input  logic                       LOOP_COUNT,
    input  logic [CNT_WIDTH-1:0]       COUNT_VAL,
    input  logic                       START_LOOP,
    input  logic                       END_LOOP,
    input  logic                       CLR_ERR,
    output logic                       REDIRECT,
    output logic [PC_WIDTH-1:0]        REDIRECT_PC,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW,
    output logic [CNT_WIDTH-1:0]       ITER
);

    localparam int LW = $clog2(DEPTH+1);

    logic [PC_WIDTH-1:0]  start_q [DEPTH];
    logic [CNT_WIDTH-1:0] rem_q   [DEPTH];

    logic [LW-1:0]        level_q;
    logic [CNT_WIDTH-1:0] pending_q;
    logic [1:0]           squash_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 redirect_p1;
    logic [PC_WIDTH-1:0]  redirect_pc_p1;

    logic [PC_WIDTH-1:0]  top_start;
    logic [CNT_WIDTH-1:0] top_rem;

    logic cmd_ok, do_end, do_start, do_count;
    logic is_empty, is_full;
    logic taken, pop, push, set_ovf, set_unf;

    // Frame i is the top of stack when level_q == i+1.
    always_comb begin
        top_start = '0;
        top_rem   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                top_start = start_q[i];
                top_rem   = rem_q[i];
            end
        end
    end

    assign cmd_ok   = !STALL && (squash_q == 2'd0);
    assign do_end   = cmd_ok && END_LOOP;
    assign do_start = cmd_ok && START_LOOP && !END_LOOP;
    assign do_count = cmd_ok && LOOP_COUNT && !END_LOOP && !START_LOOP;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LW'(DEPTH));

    assign taken   = do_end && !is_empty && (top_rem > CNT_WIDTH'(1));
    assign pop     = do_end && !is_empty && (top_rem <= CNT_WIDTH'(1));
    assign push    = do_start && !is_full;
    assign set_ovf = do_start && is_full;
    assign set_unf = do_end && is_empty;

    // Stage p0 -> p1: control state and registered redirect
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            level_q        <= '0;
            pending_q      <= CNT_WIDTH'(1);
            squash_q       <= 2'd0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
            redirect_p1    <= 1'b0;
            redirect_pc_p1 <= '0;
        end else begin
            redirect_p1 <= taken;
            if (taken) begin
                redirect_pc_p1 <= top_start;
            end

            if (taken) begin
                squash_q <= 2'(SQUASH_CYCLES);
            end else if (squash_q != 2'd0) begin
                squash_q <= squash_q - 2'd1;
            end

            if (push) begin
                level_q <= level_q + LW'(1);
            end else if (pop) begin
                level_q <= level_q - LW'(1);
            end

            if (push) begin
                pending_q <= CNT_WIDTH'(1);
            end else if (do_count) begin
                pending_q <= COUNT_VAL;
            end

            ovf_q <= (ovf_q && !CLR_ERR) || set_ovf;
            unf_q <= (unf_q && !CLR_ERR) || set_unf;
        end
    end

`ifdef LOOP_STACK_ITER_EN
    logic [CNT_WIDTH-1:0] iter_q [DEPTH];
    logic [CNT_WIDTH-1:0] top_iter;
    logic [CNT_WIDTH-1:0] below_iter;
    logic [CNT_WIDTH-1:0] iter_p1;

    // below_iter is the frame exposed by a pop; stays 0 when popping the last frame.
    always_comb begin
        top_iter   = '0;
        below_iter = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                top_iter = iter_q[i];
            end
            if (level_q == LW'(i + 2)) begin
                below_iter = iter_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && level_q == LW'(i)) begin
                iter_q[i] <= '0;
            end else if (taken && level_q == LW'(i + 1)) begin
                iter_q[i] <= iter_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            iter_p1 <= '0;
        end else if (push) begin
            iter_p1 <= '0;
        end else if (taken) begin
            iter_p1 <= top_iter + CNT_WIDTH'(1);
        end else if (pop) begin
            iter_p1 <= below_iter;
        end
    end

    assign ITER = iter_p1;
`else
    assign ITER = '0;
`endif

    // Stack frames carry no reset; only frames below level_q are ever read.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && level_q == LW'(i)) begin
                start_q[i] <= PC + PC_WIDTH'(1);
                rem_q[i]   <= pending_q;
            end else if (taken && level_q == LW'(i + 1)) begin
                rem_q[i] <= rem_q[i] - CNT_WIDTH'(1);
            end
        end
    end

    assign REDIRECT    = redirect_p1;
    assign REDIRECT_PC = redirect_pc_p1;
    assign LEVEL       = level_q;
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = unf_q;

endmodule
